// File: rtl/discrete_pkg.sv
// Shared constants and helpers for the discrete sound block.
package discrete_pkg;

  // Trigger channel indices as decoded from the sound-CPU port
  localparam int unsigned TRIG_WALK  = 0;
  localparam int unsigned TRIG_JUMP  = 1;
  localparam int unsigned TRIG_STOMP = 2;

  // Sample value that represents a 5 V level in the discrete models
  localparam logic signed [15:0] LEVEL_5V = 16'sd6826;

  // Convert a duration in milliseconds into a number of audio sample ticks
  function automatic int unsigned ms_to_samples(input int unsigned ms,
                                                input int unsigned sample_rate);
    return (ms * sample_rate) / 1000;
  endfunction

endpackage

// File: rtl/trigger_hold_channel.sv
// One trigger channel: pending flag, active flag and minimum-hold counter, all advanced on the
// audio sample tick. Build option DISCRETE_TRIG_HOLD_EN enables the pending/hold logic; without
// it the channel simply samples its request at each tick.
module trigger_hold_channel #(
  parameter int unsigned MinHold = 4
) (
  input  logic clk,
  input  logic I_RSTn,
  input  logic tick_i,
  input  logic req_i,
  input  logic set_pend_i,
  input  logic clr_all_i,
  output logic active_o,
  output logic busy_o
);

`ifdef DISCRETE_TRIG_HOLD_EN
  localparam int unsigned CntW = (MinHold > 1) ? $clog2(MinHold) : 1;
  // Reload leaves the channel high for MinHold ticks in total, floor of one tick
  localparam logic [CntW-1:0] Reload = (MinHold > 1) ? CntW'(MinHold - 1) : '0;

  logic            pend_q, pend_d;
  logic            active_q, active_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            demand;

  assign demand = req_i | pend_q;

  // Pending flag: remembers a data=1 write until the next tick consumes it
  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = 1'b0;
    end else if (set_pend_i) begin
      pend_d = 1'b1;
    end else if (tick_i) begin
      pend_d = 1'b0;
    end
  end

  // Active/hold next state: a running hold always completes, re-triggers do not extend it
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (tick_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end else if (!active_q && demand) begin
        active_d = 1'b1;
        cnt_d    = Reload;
      end else begin
        active_d = demand;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      pend_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active_o = active_q;
  assign busy_o   = (cnt_q != '0);
`else
  logic active_q;
  logic unused_pend;

  // Without hold support only the level request matters
  assign unused_pend = set_pend_i ^ clr_all_i;

  // Sample the request at each tick
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      active_q <= 1'b0;
    end else if (tick_i) begin
      active_q <= req_i;
    end
  end

  assign active_o = active_q;
  assign busy_o   = 1'b0;
`endif

endmodule

// File: rtl/discrete_trigger_latch.sv
// CPU-facing trigger latch for the discrete sound circuits. Latches single-cycle CPU writes
// into per-channel requests and re-times them onto the audio sample tick. Build option
// DISCRETE_TRIG_HOLD_EN (in trigger_hold_channel) adds pending capture and a minimum hold.
module discrete_trigger_latch
  import discrete_pkg::*;
#(
  parameter int unsigned          NUM_TRIG         = 8,
  parameter int unsigned          MIN_HOLD_SAMPLES = ms_to_samples(2, 48000),
  parameter logic [NUM_TRIG-1:0]  INVERT_MASK      = '0
) (
  input  logic                clk,
  input  logic                I_RSTn,
  input  logic                audio_clk_en,
  input  logic                cpu_wr,
  input  logic [3:0]          cpu_addr,
  input  logic                cpu_data,
  input  logic                cpu_clr_all,
  output logic [NUM_TRIG-1:0] trig_en,
  output logic                trig_busy
);

  logic [NUM_TRIG-1:0] req_q, req_d;
  logic [NUM_TRIG-1:0] set_pend;
  logic [NUM_TRIG-1:0] active;
  logic [NUM_TRIG-1:0] busy;

  // Request latch: clear-all beats a simultaneous write; out-of-range addresses never match
  always_comb begin
    req_d = req_q;
    if (cpu_clr_all) begin
      req_d = '0;
    end else if (cpu_wr) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (cpu_addr == 4'(i)) begin
          req_d[i] = cpu_data;
        end
      end
    end
  end

  // Per-channel pending set strobe (data=1 write, suppressed by clear-all)
  always_comb begin
    set_pend = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      set_pend[i] = cpu_wr & cpu_data & ~cpu_clr_all & (cpu_addr == 4'(i));
    end
  end

  // Request register
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_chan
    trigger_hold_channel #(
      .MinHold (MIN_HOLD_SAMPLES)
    ) u_chan (
      .clk        (clk),
      .I_RSTn     (I_RSTn),
      .tick_i     (audio_clk_en),
      .req_i      (req_q[g]),
      .set_pend_i (set_pend[g]),
      .clr_all_i  (cpu_clr_all),
      .active_o   (active[g]),
      .busy_o     (busy[g])
    );
  end

  assign trig_en   = active ^ INVERT_MASK;
  assign trig_busy = |busy;

endmodule

// File: tb/tb_discrete_trigger_latch.sv
// Self-checking bench for discrete_trigger_latch. Expectations adapt to whether
// DISCRETE_TRIG_HOLD_EN is defined for the build.
module tb_discrete_trigger_latch;

  localparam int unsigned NumTrig    = 8;
  localparam int unsigned MinHold    = 4;
  localparam logic [7:0]  InvMask    = 8'h01;
  localparam int unsigned TickPeriod = 20;
`ifdef DISCRETE_TRIG_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif
  localparam int MinEff = (MinHold < 1) ? 1 : int'(MinHold);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, wr, data, clr;
  logic [3:0] addr;
  logic [7:0] trig_en;
  logic       busy;

  discrete_trigger_latch #(
    .NUM_TRIG         (NumTrig),
    .MIN_HOLD_SAMPLES (MinHold),
    .INVERT_MASK      (InvMask)
  ) dut (
    .clk          (clk),
    .I_RSTn       (rst_n),
    .audio_clk_en (tick),
    .cpu_wr       (wr),
    .cpu_addr     (addr),
    .cpu_data     (data),
    .cpu_clr_all  (clr),
    .trig_en      (trig_en),
    .trig_busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: level request, "pulse seen since last tick", output level and ticks since
  // the last rising edge of the output
  bit m_req  [NumTrig];
  bit m_seen [NumTrig];
  bit m_high [NumTrig];
  int m_since[NumTrig];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_en();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < NumTrig; i++) v[i] = m_high[i];
    return v ^ InvMask;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < NumTrig; i++) begin
      if (HoldEn && m_high[i] && (m_since[i] < MinEff - 1)) b = 1'b1;
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NumTrig; i++) begin
      m_req[i] = 0; m_seen[i] = 0; m_high[i] = 0; m_since[i] = 0;
    end
  endtask

  // One clock cycle with the given CPU inputs; model advanced from pre-edge state, then checked
  task automatic step(input logic w, input logic [3:0] a, input logic d, input logic c);
    bit t;
    bit dem;
    t = ((cyc % TickPeriod) == TickPeriod - 1);
    wr = w; addr = a; data = d; clr = c; tick = t;
    if (t) begin
      for (int i = 0; i < NumTrig; i++) begin
        if (HoldEn) begin
          dem = m_req[i] | m_seen[i];
          if (m_high[i]) begin
            if (m_since[i] < 1000) m_since[i]++;
            if (m_since[i] >= MinEff) m_high[i] = dem;
          end else if (dem) begin
            m_high[i]  = 1;
            m_since[i] = 0;
          end
        end else begin
          m_high[i] = m_req[i];
        end
      end
    end
    for (int i = 0; i < NumTrig; i++) begin
      if (c) m_seen[i] = 0;
      else if (w && d && (a == 4'(i))) m_seen[i] = 1;
      else if (t) m_seen[i] = 0;
    end
    if (c) begin
      for (int i = 0; i < NumTrig; i++) m_req[i] = 0;
    end else if (w && (32'(a) < NumTrig)) begin
      m_req[a] = d;
    end
    @(posedge clk);
    #1;
    cyc++;
    wr = 0; clr = 0; tick = 0; data = 0; addr = '0;
    check("model_trig_en", 32'(trig_en), 32'(exp_en()));
    check("model_trig_busy", 32'(busy), 32'(exp_busy()));
  endtask

  task automatic run_to(input int edge_n);
    while (cyc < edge_n) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic next_tick();
    step(1'b0, 4'd0, 1'b0, 1'b0);
    while ((cyc % TickPeriod) != 0) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; checked before any clock edge
  task automatic reset_mid_cycle(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_en"}, 32'(trig_en), 32'(InvMask));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    model_clear();
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 0; wr = 0; data = 0; clr = 0; addr = '0;
    model_clear();
    #1;
    check("reset_en", 32'(trig_en), 32'(InvMask));
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;

    // Basic latency: write ch0=1 on edge 5, rise at tick edge 20, release on edge 21
    run_to(4);
    step(1'b1, 4'd0, 1'b1, 1'b0);
    run_to(19);
    check("lat_before", 32'(trig_en[0]), 32'd1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("lat_rise", 32'(trig_en[0]), 32'd0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    run_to(40);
    check("lat_t40", 32'(trig_en[0]), HoldEn ? 32'd0 : 32'd1);
    run_to(99);
    check("lat_hold_end", 32'(trig_en[0]), HoldEn ? 32'd0 : 32'd1);
    run_to(100);
    check("lat_fall", 32'(trig_en[0]), 32'd1);

    // Reset in the middle of a hold on ch0
    step(1'b1, 4'd0, 1'b1, 1'b0);
    run_to(125);
    check("pre_rst_busy", 32'(busy), HoldEn ? 32'd1 : 32'd0);
    reset_mid_cycle("rst_mid");
    run_to(2);
    check("post_rst_quiet", 32'(trig_en), 32'(InvMask));

    // Short pulse on ch2: on at edge 3, off at edge 6
    step(1'b1, 4'd2, 1'b1, 1'b0);
    run_to(5);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    run_to(19);
    check("pulse_before", 32'(trig_en[2]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      run_to(20 * (k + 1));
      check("pulse_en", 32'(trig_en[2]), (HoldEn && k < 4) ? 32'd1 : 32'd0);
      check("pulse_busy", 32'(busy), (HoldEn && k < 3) ? 32'd1 : 32'd0);
    end

    // Collision: clear-all wins over a write to ch1
    run_to(125);
    step(1'b1, 4'd1, 1'b1, 1'b1);
    run_to(185);
    check("collide_en", 32'(trig_en), 32'(InvMask));
    // Write to an address beyond the channel count
    step(1'b1, 4'd12, 1'b1, 1'b0);
    run_to(245);
    check("badaddr_en", 32'(trig_en), 32'(InvMask));
    check("badaddr_busy", 32'(busy), 32'd0);

    // Active-low ch0 held for ten ticks, then released
    step(1'b1, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      next_tick();
      check("held_low", 32'(trig_en[0]), 32'd0);
    end
    step(1'b1, 4'd0, 1'b0, 1'b0);
    next_tick();
    check("held_release", 32'(trig_en[0]), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0));
    end
    reset_mid_cycle("rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
